// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
// SPI mode-0 serial NOR flash responder (READ/PP/WREN/WRDI/RDSR), oversampled in clk.
//
// state        | meaning
// WAIT_CS_HIGH | after reset, wait for CS high so a running frame is never joined
// IDLE         | CS high, waiting for CS falling
// CMD          | shifting in the 8-bit opcode
// ADDR         | shifting in 24 address bits (upper bits alias)
// READ_DATA    | streaming array bytes on MISO
// PP_DATA      | accepting page-program data bytes
// STATUS       | streaming {6'b0, WEL, WIP} on MISO
// IGNORE       | swallow remaining bits until CS high
module spi_flash_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int PAGE_BITS   = 8,
  parameter int PROG_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_SPI_CLK,
  input  logic i_SPI_CS,
  input  logic i_SPI_MOSI,
  output logic o_SPI_MISO,
  output logic o_SPI_MISO_EN,
  output logic o_WEL,
  output logic o_WIP,
  output logic o_CMD_ERROR
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam int CNT_W = $clog2(PROG_CYCLES + 1);

  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;

  typedef enum logic [2:0] {
    WAIT_CS_HIGH, IDLE, CMD, ADDR, READ_DATA, PP_DATA, STATUS, IGNORE
  } state_t;

  typedef enum logic [1:0] {ACT_NONE, ACT_WREN, ACT_WRDI, ACT_PP} action_t;

  logic r_sck_meta, r_sck_sync, r_sck_prev;
  logic r_cs_meta, r_cs_sync, r_cs_prev;
  logic r_mosi_meta, r_mosi_sync;

  state_t  r_state, w_state_next;
  action_t r_action, w_action;
  logic    w_set_action, w_cmd_err;

  logic [2:0]           r_bit_cnt;
  logic [6:0]           r_shift;
  logic [1:0]           r_byte_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_is_read;
  logic                 r_pp_got;
  logic                 r_wel, r_wip;
  logic [CNT_W-1:0]     r_wip_cnt;
  logic [6:0]           r_tx;
  logic                 r_miso, r_miso_en, r_cmd_error;

  logic [7:0] r_mem [DEPTH] = '{default: 8'hFF};

  logic                 w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic                 w_active, w_rise_act, w_byte_done, w_mem_we, w_tx_state;
  logic [7:0]           w_byte, w_tx_src;
  logic [PAGE_BITS-1:0] w_page_next;

  assign w_sck_rise  = r_sck_sync & ~r_sck_prev;
  assign w_sck_fall  = ~r_sck_sync & r_sck_prev;
  assign w_cs_fall   = ~r_cs_sync & r_cs_prev;
  assign w_cs_rise   = r_cs_sync & ~r_cs_prev;
  assign w_active    = ~r_cs_sync & (r_state != WAIT_CS_HIGH) & (r_state != IDLE);
  assign w_rise_act  = w_sck_rise & w_active;
  assign w_byte_done = w_rise_act & (r_bit_cnt == 3'd7);
  assign w_byte      = {r_shift, r_mosi_sync};
  assign w_mem_we    = ~reset & w_byte_done & (r_state == PP_DATA) & r_wel;
  assign w_page_next = r_addr[PAGE_BITS-1:0] + PAGE_BITS'(1);
  assign w_tx_state  = (r_state == READ_DATA) | (r_state == STATUS);
  assign w_tx_src    = (r_state == READ_DATA) ? r_mem[r_addr] : {6'b0, r_wel, r_wip};

  // Synchronisers carry no reset so the true pin levels survive a reset pulse.
  always_ff @(posedge clk) begin
    r_sck_meta  <= i_SPI_CLK;
    r_sck_sync  <= r_sck_meta;
    r_sck_prev  <= r_sck_sync;
    r_cs_meta   <= i_SPI_CS;
    r_cs_sync   <= r_cs_meta;
    r_cs_prev   <= r_cs_sync;
    r_mosi_meta <= i_SPI_MOSI;
    r_mosi_sync <= r_mosi_meta;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_CS_HIGH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_err    = 1'b0;
    w_set_action = 1'b0;
    w_action     = ACT_NONE;
    case (r_state)
      WAIT_CS_HIGH: if (r_cs_sync) w_state_next = IDLE;
      IDLE:         if (w_cs_fall) w_state_next = CMD;
      CMD: begin
        if (w_byte_done) begin
          if (r_wip) begin
            w_state_next = (w_byte == OP_RDSR) ? STATUS : IGNORE;
          end else begin
            case (w_byte)
              OP_RDSR: w_state_next = STATUS;
              OP_READ: w_state_next = ADDR;
              OP_PP: begin
                w_state_next = ADDR;
                w_set_action = 1'b1;
                w_action     = ACT_PP;
              end
              OP_WREN: begin
                w_state_next = IGNORE;
                w_set_action = 1'b1;
                w_action     = ACT_WREN;
              end
              OP_WRDI: begin
                w_state_next = IGNORE;
                w_set_action = 1'b1;
                w_action     = ACT_WRDI;
              end
              default: begin
                w_state_next = IGNORE;
                w_cmd_err    = 1'b1;
              end
            endcase
          end
        end
      end
      ADDR: if (w_byte_done && r_byte_cnt == 2'd2)
              w_state_next = r_is_read ? READ_DATA : PP_DATA;
      default: ;
    endcase
    if (r_cs_sync) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_byte_cnt  <= 2'd0;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_action    <= ACT_NONE;
      r_pp_got    <= 1'b0;
      r_wel       <= 1'b0;
      r_wip       <= 1'b0;
      r_wip_cnt   <= '0;
      r_tx        <= 7'd0;
      r_miso      <= 1'b0;
      r_miso_en   <= 1'b0;
      r_cmd_error <= 1'b0;
    end else begin
      r_cmd_error <= w_cmd_err;

      if (r_wip) begin
        if (r_wip_cnt == '0) r_wip     <= 1'b0;
        else                 r_wip_cnt <= r_wip_cnt - CNT_W'(1);
      end

      if (r_cs_sync) begin
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 2'd0;
      end else if (w_rise_act) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_byte[6:0];
        if (r_state == ADDR) begin
          r_addr <= {r_addr[ADDR_BITS-2:0], r_mosi_sync};
          if (w_byte_done) r_byte_cnt <= r_byte_cnt + 2'd1;
        end
      end

      if (w_byte_done && r_state == CMD) r_is_read <= (w_byte == OP_READ);
      if (w_set_action) r_action <= w_action;

      // Page program: address wraps inside the page, upper bits held.
      if (w_mem_we) begin
        r_addr   <= {r_addr[ADDR_BITS-1:PAGE_BITS], w_page_next};
        r_pp_got <= 1'b1;
      end

      if (r_cs_sync) begin
        r_miso_en <= 1'b0;
        r_miso    <= 1'b0;
      end else if (w_sck_fall && w_tx_state) begin
        if (r_bit_cnt == 3'd0) begin
          r_tx      <= w_tx_src[6:0];
          r_miso    <= w_tx_src[7];
          r_miso_en <= 1'b1;
          if (r_state == READ_DATA) r_addr <= r_addr + ADDR_BITS'(1);
        end else begin
          r_miso <= r_tx[6];
          r_tx   <= {r_tx[5:0], 1'b0};
        end
      end

      if (w_cs_rise) begin
        r_action <= ACT_NONE;
        r_pp_got <= 1'b0;
        case (r_action)
          ACT_WREN: r_wel <= 1'b1;
          ACT_WRDI: r_wel <= 1'b0;
          ACT_PP: begin
            if (r_wel && r_pp_got) begin
              r_wel     <= 1'b0;
              r_wip     <= 1'b1;
              r_wip_cnt <= CNT_W'(PROG_CYCLES - 1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= r_mem[r_addr] & w_byte;
  end

  assign o_SPI_MISO    = r_miso;
  assign o_SPI_MISO_EN = r_miso_en;
  assign o_WEL         = r_wel;
  assign o_WIP         = r_wip;
  assign o_CMD_ERROR   = r_cmd_error;

endmodule
